pll_phase_loader: RTL and testbench

PLL_PHASE_LOADER -- requirements
Module: pll_phase_loader

---
 rtl/pll_phase_loader.sv | 186 ++++++++++++++++++
 tb/tb_pll_phase_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_loader.sv
`default_nettype none
// pll_phase_loader: byte-command loader for PLL phase shifts and clock select, with a rate-limited update strobe.
// Define PLL_LOADER_READBACK_EN to add the 'R' readback command.
module pll_phase_loader #(
    parameter logic [23:0] GUARD_CYCLES   = 24'd1000000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [7:0] phase_shifts [6],
    output logic       pll_clksrc,
    output logic       update
);
    localparam logic [7:0] OP_PHASE = 8'h50;
    localparam logic [7:0] OP_CLK   = 8'h43;
    localparam logic [7:0] OP_UPD   = 8'h55;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

`ifdef PLL_LOADER_READBACK_EN
    localparam logic [7:0] OP_READ  = 8'h52;
    typedef enum logic [2:0] {IDLE, ARG1, ARG2, RESP, RDBK} state_t;
    logic [2:0] rd_idx;
    logic [7:0] rd_byte;
`else
    typedef enum logic [1:0] {IDLE, ARG1, ARG2, RESP} state_t;
`endif

    state_t      state;
    state_t      state_nx;
    logic        is_clk_cmd;
    logic [7:0]  index;
    logic [7:0]  resp;
    logic [23:0] guard;
    logic        pending;
    logic [15:0] idle_cnt;
    logic        rx_fire;
    logic        tx_fire;
    logic        in_arg;
    logic        timed_out;
    logic        u_cmd;

    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign in_arg    = (state == ARG1) || (state == ARG2);
    assign timed_out = in_arg && !rx_valid && (idle_cnt >= TIMEOUT_CYCLES - 16'd1);
    assign u_cmd     = rx_fire && (state == IDLE) && (rx_data == OP_UPD);

`ifdef PLL_LOADER_READBACK_EN
    always_comb begin
        rd_byte = ACK;
        case (rd_idx)
            3'd0: rd_byte = phase_shifts[0];
            3'd1: rd_byte = phase_shifts[1];
            3'd2: rd_byte = phase_shifts[2];
            3'd3: rd_byte = phase_shifts[3];
            3'd4: rd_byte = phase_shifts[4];
            3'd5: rd_byte = phase_shifts[5];
            3'd6: rd_byte = {7'b0, pll_clksrc};
            default: rd_byte = ACK;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    case (rx_data)
                        OP_PHASE: state_nx = ARG1;
                        OP_CLK:   state_nx = ARG2;
`ifdef PLL_LOADER_READBACK_EN
                        OP_READ:  state_nx = RDBK;
`endif
                        default:  state_nx = RESP;
                    endcase
                end
            end
            ARG1: begin
                rx_ready = 1'b1;
                if (rx_valid)       state_nx = ARG2;
                else if (timed_out) state_nx = IDLE;
            end
            ARG2: begin
                rx_ready = 1'b1;
                if (rx_valid)       state_nx = RESP;
                else if (timed_out) state_nx = IDLE;
            end
            RESP: begin
                tx_valid = 1'b1;
                tx_data  = resp;
                if (tx_ready) state_nx = IDLE;
            end
`ifdef PLL_LOADER_READBACK_EN
            RDBK: begin
                tx_valid = 1'b1;
                tx_data  = rd_byte;
                if (tx_ready && rd_idx == 3'd7) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_clk_cmd <= 1'b0;
            index      <= 8'h00;
            resp       <= 8'h00;
            pll_clksrc <= 1'b0;
            update     <= 1'b0;
            guard      <= 24'd0;
            pending    <= 1'b0;
            idle_cnt   <= 16'd0;
            for (int i = 0; i < 6; i++) phase_shifts[i] <= 8'h00;
`ifdef PLL_LOADER_READBACK_EN
            rd_idx     <= 3'd0;
`endif
        end else begin
            update <= 1'b0;

            if (in_arg && !rx_valid) idle_cnt <= idle_cnt + 16'd1;
            else                     idle_cnt <= 16'd0;

            if (rx_fire) begin
                case (state)
                    IDLE: begin
                        is_clk_cmd <= (rx_data == OP_CLK);
                        resp       <= (rx_data == OP_UPD) ? ACK : NAK;
`ifdef PLL_LOADER_READBACK_EN
                        rd_idx     <= 3'd0;
`endif
                    end
                    ARG1: index <= rx_data;
                    ARG2: begin
                        if (is_clk_cmd) begin
                            pll_clksrc <= rx_data[0];
                            resp       <= ACK;
                        end else if (index <= 8'd5) begin
                            phase_shifts[index[2:0]] <= rx_data;
                            resp                     <= ACK;
                        end else begin
                            resp <= NAK;
                        end
                    end
                    default: ;
                endcase
            end

`ifdef PLL_LOADER_READBACK_EN
            if (state == RDBK && tx_fire) rd_idx <= rd_idx + 3'd1;
`endif

            // A deferred update fires on the edge where the guard expires; a 'U' arriving
            // with guard==1 leaves pending set with guard==0 and fires one cycle later.
            if (u_cmd && guard == 24'd0) begin
                update <= 1'b1;
                guard  <= GUARD_CYCLES;
            end else if (pending && guard <= 24'd1) begin
                update  <= 1'b1;
                guard   <= GUARD_CYCLES;
                pending <= 1'b0;
            end else begin
                if (u_cmd)              pending <= 1'b1;
                if (guard != 24'd0)     guard   <= guard - 24'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pll_phase_loader.sv
`default_nettype none
// tb_pll_phase_loader: directed vector table plus hand sequences for guard, timeout, stall and reset.
module tb_pll_phase_loader;
    localparam logic [23:0] GUARD   = 24'd100;
    localparam logic [15:0] TIMEOUT = 16'd20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic [7:0] phase_shifts [6];
    logic       pll_clksrc;
    logic       update;

    pll_phase_loader #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .phase_shifts(phase_shifts), .pll_clksrc(pll_clksrc), .update(update)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int upd_times [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (update) upd_times.push_back(cyc);

    logic [5:0][7:0] ps_flat;
    always_comb for (int i = 0; i < 6; i++) ps_flat[i] = phase_shifts[i];

    typedef struct {
        int              nb;
        logic [7:0]      b [3];
        logic [7:0]      exp_resp;
        logic [5:0][7:0] exp_ps;
        logic            exp_clk;
    } vec_t;
    vec_t vec [10];
    int   nv = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int nb, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] r, input logic [47:0] ps, input logic c);
        vec[nv].nb = nb;
        vec[nv].b[0] = b0; vec[nv].b[1] = b1; vec[nv].b[2] = b2;
        vec[nv].exp_resp = r;
        vec[nv].exp_ps = ps;
        vec[nv].exp_clk = c;
        nv++;
    endtask

    // Called and returns at a negedge; the byte transfers on the posedge in between.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (!rx_ready && w < 100) begin @(negedge clk); w++; end
        if (!rx_ready) check("rx_ready_wait", 64'd0, 64'd1);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [7:0] b);
        int w = 0;
        while (!tx_valid && w < 100) begin @(negedge clk); w++; end
        b = tx_valid ? tx_data : 8'hEE;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        int t0, n0, bad;

        // {ps5,ps4,ps3,ps2,ps1,ps0}
        add_vec(3, 8'h50, 8'h02, 8'h1F, 8'h06, 48'h00_00_00_1F_00_00, 1'b0);
        add_vec(3, 8'h50, 8'h07, 8'hAA, 8'h15, 48'h00_00_00_1F_00_00, 1'b0);
        add_vec(3, 8'h50, 8'h00, 8'h11, 8'h06, 48'h00_00_00_1F_00_11, 1'b0);
        add_vec(3, 8'h50, 8'h05, 8'hFF, 8'h06, 48'hFF_00_00_1F_00_11, 1'b0);
        add_vec(3, 8'h50, 8'h06, 8'h33, 8'h15, 48'hFF_00_00_1F_00_11, 1'b0);
        add_vec(2, 8'h43, 8'h01, 8'h00, 8'h06, 48'hFF_00_00_1F_00_11, 1'b1);
        add_vec(2, 8'h43, 8'hFE, 8'h00, 8'h06, 48'hFF_00_00_1F_00_11, 1'b0);
        add_vec(1, 8'h5A, 8'h00, 8'h00, 8'h15, 48'hFF_00_00_1F_00_11, 1'b0);
`ifndef PLL_LOADER_READBACK_EN
        add_vec(1, 8'h52, 8'h00, 8'h00, 8'h15, 48'hFF_00_00_1F_00_11, 1'b0);
`endif
        add_vec(3, 8'h50, 8'h04, 8'h42, 8'h06, 48'hFF_42_00_1F_00_11, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_update", update, 0);
        check("rst_clksrc", pll_clksrc, 0);
        check("rst_ps", ps_flat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < nv; i++) begin
            for (int j = 0; j < vec[i].nb; j++) send_byte(vec[i].b[j]);
            check($sformatf("v%0d_ps", i), ps_flat, vec[i].exp_ps);
            check($sformatf("v%0d_clk", i), pll_clksrc, vec[i].exp_clk);
            get_resp(r);
            check($sformatf("v%0d_resp", i), r, vec[i].exp_resp);
        end
        check("no_update_from_writes", upd_times.size(), 0);

        // Guard window: pulses at t0+1 and t0+101 only.
        t0 = cyc;
        send_byte(8'h55); get_resp(r); check("u1_ack", r, 8'h06);
        wait_until(t0 + 10);
        send_byte(8'h55); get_resp(r); check("u2_ack", r, 8'h06);
        wait_until(t0 + 20);
        send_byte(8'h55); get_resp(r); check("u3_ack", r, 8'h06);
        wait_until(t0 + 130);
        check("upd_count", upd_times.size(), 2);
        check("upd_t1", (upd_times.size() > 0) ? upd_times[0] - t0 : -1, 1);
        check("upd_t2", (upd_times.size() > 1) ? upd_times[1] - t0 : -1, 101);

        // Reset mid-command with an update pending.
        send_byte(8'h43); send_byte(8'h01); get_resp(r); check("pre_rst_clk", pll_clksrc, 1);
        send_byte(8'h55); get_resp(r); check("pend_ack", r, 8'h06);
        send_byte(8'h50); send_byte(8'h01);
        n0 = upd_times.size();
        rst_n = 1'b0;
        #1;
        check("arst_rx_ready", rx_ready, 1);
        check("arst_tx_valid", tx_valid, 0);
        check("arst_clksrc", pll_clksrc, 0);
        check("arst_ps", ps_flat, 0);
        check("arst_update", update, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("no_upd_after_rst", upd_times.size() - n0, 0);
        check("post_rst_tx_valid", tx_valid, 0);

`ifdef PLL_LOADER_READBACK_EN
        send_byte(8'h52);
        for (int k = 0; k < 7; k++) begin
            get_resp(r);
            check($sformatf("rdbk_%0d", k), r, 8'h00);
        end
        get_resp(r);
        check("rdbk_ack", r, 8'h06);
`endif

        // Inter-byte timeout drops the partial command silently.
        send_byte(8'h50); send_byte(8'h01);
        bad = 0;
        repeat (int'(TIMEOUT) + 5) begin
            if (tx_valid) bad++;
            @(negedge clk);
        end
        check("to_no_tx", bad, 0);
        send_byte(8'h43); send_byte(8'h01); get_resp(r);
        check("to_next_ack", r, 8'h06);
        check("to_next_clk", pll_clksrc, 1);
        check("to_ps_unchanged", ps_flat, 0);

        // A gap just under the timeout still completes the command.
        send_byte(8'h50); send_byte(8'h03);
        repeat (int'(TIMEOUT) - 3) @(negedge clk);
        send_byte(8'h77);
        check("near_to_ps3", ps_flat[3], 8'h77);
        get_resp(r);
        check("near_to_ack", r, 8'h06);

        // Response held while tx_ready stays low.
        send_byte(8'h50); send_byte(8'h00); send_byte(8'h5A);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (!tx_valid || tx_data !== 8'h06 || rx_ready) bad++;
            @(negedge clk);
        end
        check("stall_stable", bad, 0);
        get_resp(r);
        check("stall_ack", r, 8'h06);
        @(negedge clk);
        check("stall_idle_rx_ready", rx_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
